// File: rtl/dcache_if.sv
// MEM-stage <-> data cache bus: lookup, byte-serial store stream, flush.
// With DCACHE_STATS_EN defined the bus also carries the hit/miss/store counters.
interface dcache_if;
    logic [31:0] read_addr;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic        write_bit;
    logic [2:0]  write_type;
    logic [31:0] write_addr;
    logic [7:0]  write_data;
    logic        flush_i;
    logic        rd_en_i;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
    logic [31:0] store_cnt_o;
`endif

    modport master (
        output read_addr, write_bit, write_type, write_addr, write_data, flush_i, rd_en_i,
        input  cache_hit, cache_data
`ifdef DCACHE_STATS_EN
        , input hit_cnt_o, miss_cnt_o, store_cnt_o
`endif
    );

    modport slave (
        input  read_addr, write_bit, write_type, write_addr, write_data, flush_i, rd_en_i,
        output cache_hit, cache_data
`ifdef DCACHE_STATS_EN
        , output hit_cnt_o, miss_cnt_o, store_cnt_o
`endif
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, byte-granular data cache (responder side).
// Lookup is combinational over four consecutive bytes (may span two lines),
// with a same-cycle bypass from the store byte stream. Stores update one byte
// per cycle; a tag mismatch re-allocates the line keeping only the new byte.
// Optional feature macro: DCACHE_STATS_EN (hit/miss/store counters + store FSM).
module dcache #(
    parameter int INDEX_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    dcache_if.slave  bus
);
    localparam int NUM_LINES = 2 ** INDEX_W;
    localparam int TAG_W     = 30 - INDEX_W;

    // Tag/data arrays are never reset; per-byte valid flops gate their use.
    logic [TAG_W-1:0]                tag_mem  [NUM_LINES];
    logic [7:0]                      data_mem [NUM_LINES][4];
    logic [NUM_LINES-1:0][3:0]       valid_reg;

    logic [3:0]  byte_hit;
    logic [31:0] byte_val;
    logic        hit;

    // Per-byte probe: byte k lives at read_addr+k (32-bit wrap), so bytes may
    // fall into two different lines.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            logic [31:0]        b_addr;
            logic [INDEX_W-1:0] b_idx;
            logic [TAG_W-1:0]   b_tag;
            logic [1:0]         b_off;
            logic               b_bypass;
            logic               b_stored;

            assign b_addr   = bus.read_addr + 32'(gi);
            assign b_idx    = b_addr[INDEX_W+1:2];
            assign b_tag    = b_addr[31:INDEX_W+2];
            assign b_off    = b_addr[1:0];
            assign b_bypass = bus.write_bit && (bus.write_addr == b_addr);
            assign b_stored = valid_reg[b_idx][b_off] && (tag_mem[b_idx] == b_tag);
            assign byte_hit[gi]      = b_bypass | b_stored;
            assign byte_val[gi*8 +: 8] = b_bypass ? bus.write_data : data_mem[b_idx][b_off];
        end
    endgenerate

    assign hit            = (&byte_hit) & ~rst & ~bus.flush_i;
    assign bus.cache_hit  = hit;
    assign bus.cache_data = hit ? byte_val : 32'h0;

    // Store byte decode.
    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [1:0]         w_off;
    logic               w_match;
    logic               w_en;

    assign w_idx   = bus.write_addr[INDEX_W+1:2];
    assign w_tag   = bus.write_addr[31:INDEX_W+2];
    assign w_off   = bus.write_addr[1:0];
    assign w_match = (tag_mem[w_idx] == w_tag);
    assign w_en    = bus.write_bit & ~rst & ~bus.flush_i;

    // Valid bits: reset and flush clear everything; a store marks its byte,
    // and a tag change leaves only that byte valid in the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (bus.flush_i) begin
            valid_reg <= '0;
        end else if (bus.write_bit) begin
            if (w_match)
                valid_reg[w_idx][w_off] <= 1'b1;
            else
                valid_reg[w_idx] <= 4'b0001 << w_off;
        end
    end

    // Tag/data storage update (no reset, dropped on rst/flush cycles).
    always_ff @(posedge clk) begin
        if (w_en) begin
            data_mem[w_idx][w_off] <= bus.write_data;
            if (!w_match)
                tag_mem[w_idx] <= w_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    typedef enum logic {ST_IDLE, ST_STORE} store_state_t;

    store_state_t state_reg;
    logic         prev_write_bit_reg;
    logic [2:0]   store_type_reg;
    logic [31:0]  hit_cnt_reg;
    logic [31:0]  miss_cnt_reg;
    logic [31:0]  store_cnt_reg;
    logic         store_start;

    // A store begins on a rising edge of write_bit; tail cycles of SH/SW stay in STORE.
    assign store_start = (state_reg == ST_IDLE) && bus.write_bit && !prev_write_bit_reg;

    // Store FSM and saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            prev_write_bit_reg <= 1'b0;
            store_type_reg     <= 3'd0;
            hit_cnt_reg        <= 32'd0;
            miss_cnt_reg       <= 32'd0;
            store_cnt_reg      <= 32'd0;
        end else begin
            prev_write_bit_reg <= bus.write_bit;
            if (bus.rd_en_i) begin
                if (hit) begin
                    if (hit_cnt_reg != 32'hFFFF_FFFF) hit_cnt_reg <= hit_cnt_reg + 32'd1;
                end else begin
                    if (miss_cnt_reg != 32'hFFFF_FFFF) miss_cnt_reg <= miss_cnt_reg + 32'd1;
                end
            end
            if (bus.flush_i) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (store_start) begin
                            state_reg      <= ST_STORE;
                            store_type_reg <= bus.write_type;
                            if (store_cnt_reg != 32'hFFFF_FFFF) store_cnt_reg <= store_cnt_reg + 32'd1;
                        end
                    end
                    ST_STORE: begin
                        if (!bus.write_bit) state_reg <= ST_IDLE;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.hit_cnt_o   = hit_cnt_reg;
    assign bus.miss_cnt_o  = miss_cnt_reg;
    assign bus.store_cnt_o = store_cnt_reg;
`endif
endmodule

// File: tb/tb_dcache.sv
// Testbench for dcache: directed table of store/lookup vectors, hand-written
// flush/reset sequences, then randomized traffic against a byte-level model.
module tb_dcache;
    localparam int NUM_LINES = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_if bus ();

    dcache #(.INDEX_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef enum {OP_READ, OP_SW, OP_SB} op_t;
    typedef struct {
        op_t         op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_hit;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    // Model: set of resident bytes keyed by byte address. Direct mapping means
    // a line holds bytes of one 4-byte block only.
    logic [7:0] model [bit [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.read_addr  = 32'h0;
        bus.write_bit  = 1'b0;
        bus.write_type = 3'd0;
        bus.write_addr = 32'h0;
        bus.write_data = 8'h0;
        bus.flush_i    = 1'b0;
        bus.rd_en_i    = 1'b0;
    endtask

    // Starts and ends at posedge+1.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int n, input logic [2:0] wt);
        logic [31:0] dv;
        dv = d;
        for (int i = 0; i < n; i++) begin
            bus.write_bit  = 1'b1;
            bus.write_type = wt;
            bus.write_addr = a + 32'(i);
            bus.write_data = dv[i*8 +: 8];
            @(posedge clk); #1;
        end
        bus.write_bit = 1'b0;
        $display("store addr=%h data=%h bytes=%0d", a, d, n);
    endtask

    task automatic do_read(input string name, input logic [31:0] a, input logic eh, input logic [31:0] ed);
        bus.read_addr = a;
        bus.write_bit = 1'b0;
        bus.flush_i   = 1'b0;
        @(negedge clk);
        $display("read %s addr=%h hit=%0b data=%h", name, a, bus.cache_hit, bus.cache_data);
        check({name, "_hit"}, {31'd0, bus.cache_hit}, {31'd0, eh});
        check({name, "_data"}, bus.cache_data, ed);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        bus.read_addr = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hit", {31'd0, bus.cache_hit}, 32'd0);
        check("rst_data", bus.cache_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic void model_write(input logic [31:0] a, input logic [7:0] d);
        bit [31:0] victims [$];
        bit [31:0] blk;
        blk = a >> 2;
        foreach (model[k]) begin
            if ((((k >> 2) % NUM_LINES) == (blk % NUM_LINES)) && ((k >> 2) != blk))
                victims.push_back(k);
        end
        foreach (victims[i]) model.delete(victims[i]);
        model[a] = d;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        case ($urandom_range(0, 2))
            0:       base = 32'h0000_0000;
            1:       base = 32'h0000_0100;
            default: base = 32'hFFFF_FFF0;
        endcase
        return base + 32'($urandom_range(0, 31));
    endfunction

    initial begin
        rst = 1'b1;
        idle_inputs();

        vecs[0]  = '{OP_READ, 32'h100, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{OP_SW,   32'h100, 32'hDEADBEEF,  1'b0, 32'h0};
        vecs[2]  = '{OP_READ, 32'h100, 32'h0,         1'b1, 32'hDEADBEEF};
        vecs[3]  = '{OP_SW,   32'h104, 32'h11223344,  1'b0, 32'h0};
        vecs[4]  = '{OP_READ, 32'h102, 32'h0,         1'b1, 32'h3344DEAD};
        vecs[5]  = '{OP_READ, 32'h106, 32'h0,         1'b0, 32'h0};
        vecs[6]  = '{OP_SB,   32'h200, 32'h55,        1'b0, 32'h0};
        vecs[7]  = '{OP_READ, 32'h100, 32'h0,         1'b0, 32'h0};
        vecs[8]  = '{OP_READ, 32'h200, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{OP_SW,   32'h200, 32'hCAFEF00D,  1'b0, 32'h0};
        vecs[10] = '{OP_READ, 32'h200, 32'h0,         1'b1, 32'hCAFEF00D};
        vecs[11] = '{OP_READ, 32'h104, 32'h0,         1'b1, 32'h11223344};

        apply_reset();

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            case (vecs[i].op)
                OP_SW:   do_store(vecs[i].addr, vecs[i].data, 4, 3'd2);
                OP_SB:   do_store(vecs[i].addr, vecs[i].data, 1, 3'd0);
                default: do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_data);
            endcase
        end

        // Flush with a concurrent store: lookup gated, store dropped.
        bus.flush_i    = 1'b1;
        bus.write_bit  = 1'b1;
        bus.write_addr = 32'h100;
        bus.write_data = 8'h77;
        bus.read_addr  = 32'h200;
        @(negedge clk);
        $display("flush cycle hit=%0b data=%h", bus.cache_hit, bus.cache_data);
        check("flush_gate_hit", {31'd0, bus.cache_hit}, 32'd0);
        @(posedge clk); #1;
        bus.flush_i   = 1'b0;
        bus.write_bit = 1'b0;
        do_read("post_flush_200", 32'h200, 1'b0, 32'h0);
        do_read("post_flush_104", 32'h104, 1'b0, 32'h0);
        do_store(32'h101, 32'h332211, 3, 3'd0);
        do_read("flush_drop_100", 32'h100, 1'b0, 32'h0);
        do_store(32'h100, 32'h99, 1, 3'd0);
        do_read("refill_100", 32'h100, 1'b1, 32'h33221199);

        // Reset in the middle of a word store.
        do_store(32'h300, 32'hA1A2A3A4, 2, 3'd2);
        rst            = 1'b1;
        bus.write_bit  = 1'b1;
        bus.write_addr = 32'h302;
        bus.write_data = 8'hA2;
        bus.read_addr  = 32'h100;
        @(negedge clk);
        $display("reset cycle hit=%0b data=%h", bus.cache_hit, bus.cache_data);
        check("midrst_hit", {31'd0, bus.cache_hit}, 32'd0);
        check("midrst_data", bus.cache_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.write_bit = 1'b0;
        do_store(32'h302, 32'hA1A2, 2, 3'd2);
        do_read("midrst_300", 32'h300, 1'b0, 32'h0);
        do_read("midrst_100", 32'h100, 1'b0, 32'h0);

`ifdef DCACHE_STATS_EN
        // Statistics: two hit strobes, one miss strobe, one SW.
        apply_reset();
        do_store(32'h40, 32'h01020304, 4, 3'd2);
        bus.read_addr = 32'h40;
        bus.rd_en_i   = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("stats_hit_lookup", {31'd0, bus.cache_hit}, 32'd1);
            @(posedge clk); #1;
        end
        bus.read_addr = 32'h80;
        @(negedge clk);
        check("stats_miss_lookup", {31'd0, bus.cache_hit}, 32'd0);
        @(posedge clk); #1;
        bus.rd_en_i = 1'b0;
        $display("stats hit=%0d miss=%0d store=%0d", bus.hit_cnt_o, bus.miss_cnt_o, bus.store_cnt_o);
        check("hit_cnt", bus.hit_cnt_o, 32'd2);
        check("miss_cnt", bus.miss_cnt_o, 32'd1);
        check("store_cnt", bus.store_cnt_o, 32'd1);
`endif

        // Randomized traffic against the byte-level model.
        apply_reset();
        model.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic        fl;
            logic        wb;
            logic [31:0] wa;
            logic [7:0]  wd;
            logic [31:0] ra;
            logic [31:0] b;
            logic [31:0] exp_val;
            logic        exp_hit;

            fl = ($urandom_range(0, 63) == 0);
            wb = 1'($urandom_range(0, 1));
            wa = rand_addr();
            wd = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                ra = wa - 32'($urandom_range(0, 3));
            else
                ra = rand_addr();

            bus.flush_i    = fl;
            bus.write_bit  = wb;
            bus.write_addr = wa;
            bus.write_data = wd;
            bus.read_addr  = ra;

            exp_hit = !fl;
            exp_val = 32'h0;
            for (int k = 0; k < 4; k++) begin
                b = ra + 32'(k);
                if (wb && (wa == b))
                    exp_val[k*8 +: 8] = wd;
                else if (model.exists(b))
                    exp_val[k*8 +: 8] = model[b];
                else
                    exp_hit = 1'b0;
            end
            if (!exp_hit) exp_val = 32'h0;

            @(negedge clk);
            $display("rand %0d ra=%h wb=%0b wa=%h fl=%0b hit=%0b data=%h", cyc, ra, wb, wa, fl,
                     bus.cache_hit, bus.cache_data);
            check("rand_hit", {31'd0, bus.cache_hit}, {31'd0, exp_hit});
            check("rand_data", bus.cache_data, exp_val);
            @(posedge clk);
            if (fl)
                model.delete();
            else if (wb)
                model_write(wa, wd);
            #1;
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
